// File: rtl/asg_sweep_ctrl.sv
// Frequency-sweep sequencer for one ASG channel.
// Steps the channel phase increment from start to stop in once/repeat/ping-pong modes.
module asg_sweep_ctrl #(
    parameter int SW = 32,
    parameter int CW = 16
) (
    input  logic          dac_clk_i,
    input  logic          dac_rst_i,
    input  logic          cfg_en_i,
    input  logic [1:0]    cfg_mode_i,
    input  logic [SW-1:0] cfg_start_i,
    input  logic [SW-1:0] cfg_stop_i,
    input  logic [SW-1:0] cfg_incr_i,
    input  logic [31:0]   cfg_period_i,
    input  logic          trig_i,
    input  logic          stop_i,
    output logic [SW-1:0] step_o,
    output logic          step_vld_o,
    output logic          busy_o,
    output logic          done_o,
    output logic [CW-1:0] sweep_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    mode_q, mode_d;
    logic [SW-1:0] start_q, start_d;
    logic [SW-1:0] stop_q, stop_d;
    logic [SW-1:0] incr_q, incr_d;
    logic [31:0]   per_q, per_d;
    logic [31:0]   hold_q, hold_d;
    logic          dir_q, dir_d;
    logic          rev_q, rev_d;
    logic          leg_end_q, leg_end_d;
    logic [SW-1:0] step_d;
    logic          vld_d, busy_d, done_d;
    logic [CW-1:0] cnt_d, cnt_inc;

    logic          trig_go, abort, tick, once;
    logic          leg_up;
    logic [SW-1:0] tgt_fw, tgt_rv;
    logic [SW:0]   upd_fw, upd_rv;

    // MSB = stop reached (incl. carry/borrow), LSBs = clamped next value
    function automatic logic [SW:0] upd(
        input logic [SW-1:0] cur,
        input logic [SW-1:0] inc,
        input logic [SW-1:0] tgt,
        input logic          up
    );
        logic [SW:0] nxt;
        logic        hit;
        if (up) begin
            nxt = {1'b0, cur} + {1'b0, inc};
            hit = nxt >= {1'b0, tgt};
        end else begin
            nxt = {1'b0, cur} - {1'b0, inc};
            hit = nxt[SW] || (nxt[SW-1:0] <= tgt);
        end
        return {hit, hit ? tgt : nxt[SW-1:0]};
    endfunction

    assign trig_go = trig_i && cfg_en_i && !stop_i;
    assign abort   = stop_i || !cfg_en_i;
    assign tick    = (hold_q == 32'd0);
    assign once    = (mode_q[1] == mode_q[0]);
    assign leg_up  = dir_q ^ rev_q;
    assign tgt_fw  = rev_q ? start_q : stop_q;
    assign tgt_rv  = rev_q ? stop_q : start_q;
    assign upd_fw  = upd(step_o, incr_q, tgt_fw, leg_up);
    assign upd_rv  = upd(step_o, incr_q, tgt_rv, ~leg_up);
    assign cnt_inc = (&sweep_cnt_o) ? sweep_cnt_o : sweep_cnt_o + CW'(1);

    always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
        if (dac_rst_i) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (trig_go) state_d = S_RUN;
            S_RUN: begin
                if (abort)                         state_d = S_IDLE;
                else if (tick && leg_end_q && once) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mode_d    = mode_q;
        start_d   = start_q;
        stop_d    = stop_q;
        incr_d    = incr_q;
        per_d     = per_q;
        hold_d    = hold_q;
        dir_d     = dir_q;
        rev_d     = rev_q;
        leg_end_d = leg_end_q;
        step_d    = step_o;
        cnt_d     = sweep_cnt_o;
        vld_d     = 1'b0;
        busy_d    = (state_d == S_RUN);
        done_d    = (state_q == S_RUN) && (state_d == S_DONE);
        if (state_q == S_IDLE && trig_go) begin
            mode_d    = cfg_mode_i;
            start_d   = cfg_start_i;
            stop_d    = cfg_stop_i;
            incr_d    = cfg_incr_i;
            per_d     = (cfg_period_i == 32'd0) ? 32'd0 : cfg_period_i - 32'd1;
            hold_d    = per_d;
            dir_d     = (cfg_start_i <= cfg_stop_i);
            rev_d     = 1'b0;
            leg_end_d = (cfg_start_i == cfg_stop_i);
            step_d    = cfg_start_i;
            cnt_d     = '0;
            vld_d     = 1'b1;
        end else if (state_q == S_RUN && !abort) begin
            if (!tick) begin
                hold_d = hold_q - 32'd1;
            end else begin
                hold_d = per_q;
                if (!leg_end_q) begin
                    step_d    = upd_fw[SW-1:0];
                    leg_end_d = upd_fw[SW];
                    if (upd_fw[SW] && mode_q == 2'd2 && rev_q) cnt_d = cnt_inc;
                end else if (mode_q == 2'd1) begin
                    step_d    = start_q;
                    leg_end_d = (start_q == stop_q);
                    cnt_d     = cnt_inc;
                end else if (mode_q == 2'd2) begin
                    // turn around and take the first step of the new leg at once
                    rev_d     = ~rev_q;
                    step_d    = upd_rv[SW-1:0];
                    leg_end_d = upd_rv[SW];
                    if (upd_rv[SW] && !rev_q) cnt_d = cnt_inc;
                end
                vld_d = (step_d != step_o);
            end
        end
    end

    always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
        if (dac_rst_i) begin
            mode_q      <= '0;
            start_q     <= '0;
            stop_q      <= '0;
            incr_q      <= '0;
            per_q       <= '0;
            hold_q      <= '0;
            dir_q       <= 1'b0;
            rev_q       <= 1'b0;
            leg_end_q   <= 1'b0;
            step_o      <= '0;
            step_vld_o  <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            sweep_cnt_o <= '0;
        end else begin
            mode_q      <= mode_d;
            start_q     <= start_d;
            stop_q      <= stop_d;
            incr_q      <= incr_d;
            per_q       <= per_d;
            hold_q      <= hold_d;
            dir_q       <= dir_d;
            rev_q       <= rev_d;
            leg_end_q   <= leg_end_d;
            step_o      <= step_d;
            step_vld_o  <= vld_d;
            busy_o      <= busy_d;
            done_o      <= done_d;
            sweep_cnt_o <= cnt_d;
        end
    end

endmodule

// File: tb/tb_asg_sweep_ctrl.sv
// Bench for asg_sweep_ctrl: directed plus randomized sweeps
// against a value-list reference model.
module tb_asg_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_en;
    logic [1:0]  cfg_mode;
    logic [31:0] cfg_start, cfg_stop, cfg_incr, cfg_period;
    logic        trig, stop;
    logic [31:0] step;
    logic        step_vld, busy, done;
    logic [15:0] sweep_cnt;

    int n_chk = 0;
    int n_err = 0;

    longint q_val[$];
    int     q_cnt[$];
    int     cur_cnt;
    int     g_p, g_l;
    bit     g_fin;

    asg_sweep_ctrl #(.SW(32), .CW(16)) dut (
        .dac_clk_i   (clk),
        .dac_rst_i   (rst),
        .cfg_en_i    (cfg_en),
        .cfg_mode_i  (cfg_mode),
        .cfg_start_i (cfg_start),
        .cfg_stop_i  (cfg_stop),
        .cfg_incr_i  (cfg_incr),
        .cfg_period_i(cfg_period),
        .trig_i      (trig),
        .stop_i      (stop),
        .step_o      (step),
        .step_vld_o  (step_vld),
        .busy_o      (busy),
        .done_o      (done),
        .sweep_cnt_o (sweep_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // one leg: every value shown, clamped to b
    function automatic void push_leg(input longint a, input longint b,
                                     input longint inc, input bit skip_first);
        longint v;
        v = a;
        if (!skip_first) begin
            q_val.push_back(v);
            q_cnt.push_back(cur_cnt);
        end
        while (v != b) begin
            if (a <= b) begin
                v = v + inc;
                if (v >= b) v = b;
            end else begin
                v = v - inc;
                if (v <= b) v = b;
            end
            q_val.push_back(v);
            q_cnt.push_back(cur_cnt);
        end
    endfunction

    function automatic void build(input int mode, input longint s, input longint e,
                                  input longint inc, input int nblk);
        q_val.delete();
        q_cnt.delete();
        cur_cnt = 0;
        push_leg(s, e, inc, 1'b0);
        g_fin = (mode == 0 || mode == 3);
        if (mode == 1) begin
            while (q_val.size() < nblk) begin
                cur_cnt++;
                push_leg(s, e, inc, 1'b0);
            end
        end else if (mode == 2) begin
            while (q_val.size() < nblk) begin
                push_leg(e, s, inc, 1'b1);
                cur_cnt++;
                q_cnt[q_cnt.size()-1] = cur_cnt;
                push_leg(s, e, inc, 1'b1);
            end
        end
        g_l = q_val.size();
    endfunction

    function automatic void expect_at(input int t, output longint v, output bit vld,
                                      output bit bsy, output bit dn, output int cnt);
        int idx;
        idx = t / g_p;
        if (g_fin && idx >= g_l) begin
            v   = q_val[g_l-1];
            vld = 1'b0;
            bsy = 1'b0;
            dn  = (t == g_l * g_p);
            cnt = 0;
        end else begin
            v   = q_val[idx];
            cnt = q_cnt[idx];
            bsy = 1'b1;
            dn  = 1'b0;
            vld = (t % g_p == 0) && (idx == 0 || q_val[idx] != q_val[idx-1]);
        end
    endfunction

    task automatic run_sweep(input int mode, input longint s, input longint e,
                             input longint inc, input int per, input int ncyc,
                             input int retrig_t, input bit by_en);
        longint v;
        bit     vld, bsy, dn;
        int     cnt;
        g_p = (per == 0) ? 1 : per;
        build(mode, s, e, inc, ncyc / g_p + 3);
        cfg_mode   = 2'(mode);
        cfg_start  = s[31:0];
        cfg_stop   = e[31:0];
        cfg_incr   = inc[31:0];
        cfg_period = 32'(per);
        cfg_en     = 1'b1;
        trig       = 1'b1;
        @(negedge clk);
        trig       = 1'b0;
        // config is latched at trigger; later changes must not matter
        cfg_mode   = 2'($urandom);
        cfg_start  = $urandom;
        cfg_stop   = $urandom;
        cfg_incr   = $urandom;
        cfg_period = $urandom_range(0, 7);
        for (int t = 0; t < ncyc; t++) begin
            expect_at(t, v, vld, bsy, dn, cnt);
            chk("step", longint'(step), v);
            chk("vld", longint'(step_vld), longint'(vld));
            chk("busy", longint'(busy), longint'(bsy));
            chk("done", longint'(done), longint'(dn));
            chk("cnt", longint'(sweep_cnt), longint'(cnt));
            trig = (t == retrig_t);
            @(negedge clk);
        end
        trig = 1'b0;
        expect_at(ncyc, v, vld, bsy, dn, cnt);
        if (by_en) cfg_en = 1'b0;
        else       stop   = 1'b1;
        @(negedge clk);
        chk("abort_busy", longint'(busy), 0);
        chk("abort_step", longint'(step), v);
        chk("abort_vld", longint'(step_vld), 0);
        chk("abort_done", longint'(done), 0);
        stop   = 1'b0;
        cfg_en = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst        = 1'b1;
        cfg_en     = 1'b1;
        cfg_mode   = '0;
        cfg_start  = '0;
        cfg_stop   = '0;
        cfg_incr   = '0;
        cfg_period = '0;
        trig       = 1'b0;
        stop       = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_step", longint'(step), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_done", longint'(done), 0);
        chk("rst_vld", longint'(step_vld), 0);
        chk("rst_cnt", longint'(sweep_cnt), 0);
        rst = 1'b0;
        @(negedge clk);

        run_sweep(0, 100, 130, 10, 4, 20, -1, 1'b0);
        run_sweep(0, 50, 5, 20, 1, 6, -1, 1'b0);
        run_sweep(0, 15, 0, 20, 1, 4, -1, 1'b1);
        run_sweep(1, 0, 3, 1, 2, 26, 9, 1'b0);
        run_sweep(2, 0, 2, 1, 1, 10, -1, 1'b1);
        run_sweep(3, 64'hFFFF_FFF0, 64'hFFFF_FFFF, 64'h20, 2, 6, -1, 1'b0);
        run_sweep(1, 7, 7 + 5, 5, 0, 6, -1, 1'b0);

        // trig together with stop in IDLE must not start
        cfg_mode  = 2'd0;
        cfg_start = 32'd10;
        cfg_stop  = 32'd20;
        cfg_incr  = 32'd1;
        trig      = 1'b1;
        stop      = 1'b1;
        @(negedge clk);
        trig = 1'b0;
        stop = 1'b0;
        chk("trigstop_busy", longint'(busy), 0);
        chk("trigstop_vld", longint'(step_vld), 0);

        // asynchronous reset between edges
        cfg_mode   = 2'd1;
        cfg_start  = 32'd0;
        cfg_stop   = 32'd3;
        cfg_incr   = 32'd1;
        cfg_period = 32'd2;
        trig       = 1'b1;
        @(negedge clk);
        trig = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_step", longint'(step), 0);
        chk("arst_busy", longint'(busy), 0);
        chk("arst_cnt", longint'(sweep_cnt), 0);
        chk("arst_vld", longint'(step_vld), 0);
        chk("arst_done", longint'(done), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_sweep(1, 0, 3, 1, 2, 12, -1, 1'b0);

        for (int i = 0; i < 25; i++) begin
            longint s, e;
            s = longint'($urandom_range(0, 300));
            e = longint'($urandom_range(0, 300));
            if (e == s) e = s + 1;
            run_sweep(int'($urandom_range(0, 3)), s, e,
                      longint'($urandom_range(1, 80)),
                      int'($urandom_range(0, 4)),
                      int'($urandom_range(3, 50)), -1, 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
